// File: rtl/gshare_predictor_pkg.sv
// Shared constants and helpers for the gshare branch predictor.
// RISC-V control-flow opcodes, register numbers used for return-address
// detection, immediate extraction and 2-bit counter saturation.
package gshare_predictor_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [4:0] REG_RA    = 5'd1;

  typedef logic [31:0] addr_t;

  function automatic addr_t imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic addr_t imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? c : c + 2'd1;
    else    return (c == 2'd0) ? c : c - 2'd1;
  endfunction
endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch / prediction / commit / statistics bundle of the predictor.
// master: fetch and commit source (front end + ROB); slave: the predictor.
interface gshare_predictor_if #(parameter int GHR_W = 8);
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_inst;
  logic [31:0]      pred_pc;
  logic             pred_jump;
  logic [GHR_W-1:0] pred_ghr;
  logic             rob_br;
  logic             rob_br_jump;
  logic [31:0]      rob_br_pc;
  logic [GHR_W-1:0] rob_br_ghr;
  logic             rob_flush;
  logic [31:0]      stat_br_cnt;
  logic [31:0]      stat_miss_cnt;

  modport master (
    output fetch_valid, fetch_pc, fetch_inst,
    output rob_br, rob_br_jump, rob_br_pc, rob_br_ghr, rob_flush,
    input  pred_pc, pred_jump, pred_ghr, stat_br_cnt, stat_miss_cnt
  );
  modport slave (
    input  fetch_valid, fetch_pc, fetch_inst,
    input  rob_br, rob_br_jump, rob_br_pc, rob_br_ghr, rob_flush,
    output pred_pc, pred_jump, pred_ghr, stat_br_cnt, stat_miss_cnt
  );
endinterface

// File: rtl/gshare_predictor_ras_stack.sv
// Circular return-address stack.
// Ports: clk, rst (async active-low), push/pop/clear strobes, push_addr,
// top (newest entry), empty. A push when full overwrites the oldest entry;
// a pop when empty is ignored. clear wins over push/pop.
module ras_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] push_addr,
  output logic [31:0] top,
  output logic        empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][31:0] r_mem;
  logic [PW-1:0]          r_ptr;   // next free slot; top lives at r_ptr-1
  logic [PW:0]            r_cnt;
  logic [PW-1:0]          w_top_idx;

  assign w_top_idx = r_ptr - 1'b1;
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end else if (pop && !empty) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Entries are only read behind a nonzero count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_ptr] <= push_addr;
  end
endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch predictor with return-address stack.
// Ports: clk, rst (async active-low), rdy (stall when low), bus (slave side
// of gshare_predictor_if: fetch in, prediction out, commit in, stats out).
// Prediction is combinational on the fetch inputs; all state updates on clk.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_W     = 8,
  parameter int GHR_W     = 8,
  parameter int MODE      = 1,
  parameter int RAS_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  gshare_predictor_if.slave bus
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0][1:0] r_bht;
  logic [GHR_W-1:0]  r_ghr;
  logic [31:0]       r_br_cnt, r_miss_cnt;

  logic [IDX_W-1:0]  w_ghr_ext, w_upd_ext, w_f_idx, w_u_idx;
  logic [6:0]        w_op;
  logic [4:0]        w_rd, w_rs1;
  logic [31:0]       w_pc4, w_pred_pc, w_ras_top;
  logic              w_pred_jump, w_is_br, w_push, w_pop, w_ras_empty;
  logic              w_spec_ok;
  logic [GHR_W:0]    w_ghr_spec, w_ghr_fix;
  logic              w_unused_pc;

  assign w_op  = bus.fetch_inst[6:0];
  assign w_rd  = bus.fetch_inst[11:7];
  assign w_rs1 = bus.fetch_inst[19:15];
  assign w_pc4 = bus.fetch_pc + 32'd4;

  // History is zero-extended up to the index width before hashing.
  always_comb begin
    w_ghr_ext = '0;
    w_upd_ext = '0;
    w_ghr_ext[GHR_W-1:0] = r_ghr;
    w_upd_ext[GHR_W-1:0] = bus.rob_br_ghr;
  end

  assign w_f_idx = bus.fetch_pc[IDX_W+1:2]  ^ ((MODE == 1) ? w_ghr_ext : '0);
  assign w_u_idx = bus.rob_br_pc[IDX_W+1:2] ^ ((MODE == 1) ? w_upd_ext : '0);
  assign w_unused_pc = ^{bus.rob_br_pc[31:IDX_W+2], bus.rob_br_pc[1:0]};

  always_comb begin
    w_pred_pc   = w_pc4;
    w_pred_jump = 1'b0;
    w_is_br     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (rst && bus.fetch_valid) begin
      case (w_op)
        OP_BRANCH: begin
          w_is_br = 1'b1;
          if (r_bht[w_f_idx][1]) begin
            w_pred_pc   = bus.fetch_pc + imm_b(bus.fetch_inst);
            w_pred_jump = 1'b1;
          end
        end
        OP_JAL: begin
          w_pred_pc   = bus.fetch_pc + imm_j(bus.fetch_inst);
          w_pred_jump = 1'b1;
          w_push      = (w_rd == REG_RA);
        end
        OP_JALR: begin
          // Only the canonical return (jalr x0, 0(x1)) uses the stack.
          if (w_rs1 == REG_RA && w_rd == REG_ZERO && !w_ras_empty) begin
            w_pred_pc   = w_ras_top;
            w_pred_jump = 1'b1;
            w_pop       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A flush kills whatever fetch happens in the same cycle.
  assign w_spec_ok  = rdy && !bus.rob_flush;
  assign w_ghr_spec = {r_ghr, w_pred_jump};
  assign w_ghr_fix  = {bus.rob_br_ghr, bus.rob_br_jump};

  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push && w_spec_ok),
    .pop       (w_pop && w_spec_ok),
    .clear     (rdy && bus.rob_flush),
    .push_addr (w_pc4),
    .top       (w_ras_top),
    .empty     (w_ras_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bht      <= '0;
      r_ghr      <= '0;
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (rdy) begin
      if (bus.rob_br) begin
        r_bht[w_u_idx] <= sat_upd(r_bht[w_u_idx], bus.rob_br_jump);
        r_br_cnt       <= r_br_cnt + 32'd1;
        if (bus.rob_flush) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
      // Repair from the resolved branch's snapshot; a bare flush keeps GHR.
      if (bus.rob_flush) begin
        if (bus.rob_br) r_ghr <= w_ghr_fix[GHR_W-1:0];
      end else if (w_is_br) begin
        r_ghr <= w_ghr_spec[GHR_W-1:0];
      end
    end
  end

  assign bus.pred_pc       = w_pred_pc;
  assign bus.pred_jump     = w_pred_jump;
  assign bus.pred_ghr      = r_ghr;
  assign bus.stat_br_cnt   = r_br_cnt;
  assign bus.stat_miss_cnt = r_miss_cnt;
endmodule
